// File: rtl/rr_mux_stream_if.sv
// Stream bundle for rr_mux_stream: N producer channels in, one consumer channel out.
// With RR_MUX_STREAM_PKT_LOCK_EN defined, per-channel in_last and registered out_last are added.
interface rr_mux_stream_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SELW  = 2
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_sel;
   logic               out_valid;
   logic               out_ready;
`ifdef RR_MUX_STREAM_PKT_LOCK_EN
   logic [N-1:0]       in_last;
   logic               out_last;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_sel, out_valid, out_last
   );
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_sel, out_valid, out_last
   );
`else
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_valid
   );
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_valid
   );
`endif
endinterface

// File: rtl/rr_mux_stream.sv
// N-channel round-robin streaming mux with one registered output stage.
// Optional RR_MUX_STREAM_PKT_LOCK_EN: hold the grant on one channel until its in_last beat.
module rr_mux_stream #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SELW  = 2
) (
   input logic          clock,
   input logic          reset,
   rr_mux_stream_if.slave bus
);
   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  ptr_nxt;
   logic [SELW-1:0]  gnt;
   logic [SELW-1:0]  hi_idx;
   logic [SELW-1:0]  lo_idx;
   logic             hi_found;
   logic             lo_found;
   logic             gnt_vld;
   logic             can_load;
   logic             xfer;
   logic             adv_ptr;
   logic [WIDTH-1:0] sel_data;

   // Lowest valid index at or above ptr wins; otherwise lowest valid index below ptr.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (bus.in_valid[i]) begin
            if (SELW'(i) >= ptr) begin
               hi_found = 1'b1;
               hi_idx   = SELW'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = SELW'(i);
            end
         end
      end
   end

`ifdef RR_MUX_STREAM_PKT_LOCK_EN
   typedef enum logic {S_OPEN, S_LOCK} lock_t;
   lock_t           state_q, state_d;
   logic [SELW-1:0] lock_ch_q, lock_ch_d;
   logic            lock_vld;
   logic            sel_last;

   // While locked, only the owning channel can be granted, even if it drops valid.
   always_comb begin
      lock_vld = 1'b0;
      sel_last = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (lock_ch_q == SELW'(i)) lock_vld = bus.in_valid[i];
         if (gnt == SELW'(i))       sel_last = bus.in_last[i];
      end
      if (state_q == S_LOCK) begin
         gnt     = lock_ch_q;
         gnt_vld = lock_vld;
      end else begin
         gnt     = hi_found ? hi_idx : lo_idx;
         gnt_vld = hi_found || lo_found;
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      case (state_q)
         S_OPEN:  if (xfer && !sel_last) begin
                     state_d   = S_LOCK;
                     lock_ch_d = gnt;
                  end
         S_LOCK:  if (xfer && sel_last) state_d = S_OPEN;
         default: state_d = S_OPEN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_OPEN;
         lock_ch_q    <= '0;
         bus.out_last <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_ch_q <= lock_ch_d;
         if (xfer) bus.out_last <= sel_last;
      end
   end

   assign adv_ptr = xfer && sel_last;
`else
   assign gnt     = hi_found ? hi_idx : lo_idx;
   assign gnt_vld = hi_found || lo_found;
   assign adv_ptr = xfer;
`endif

   assign can_load = !bus.out_valid || bus.out_ready;
   assign xfer     = !reset && can_load && gnt_vld;
   assign ptr_nxt  = (gnt == SELW'(N - 1)) ? '0 : gnt + SELW'(1);

   // One-hot ready and data select for the granted channel.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < int'(N); i++) begin
         bus.in_ready[i] = xfer && (gnt == SELW'(i));
         if (gnt == SELW'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output register: load on transfer, otherwise drain when the consumer takes the beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sel   <= '0;
         ptr           <= '0;
      end else begin
         if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sel_data;
            bus.out_sel   <= gnt;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (adv_ptr) ptr <= ptr_nxt;
      end
   end
endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed, table-driven bench for rr_mux_stream (N=4, WIDTH=16); channel i always presents 16'h1000+i.
module tb_rr_mux_stream;
   localparam int unsigned N     = 4;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned SELW  = 2;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   rr_mux_stream_if #(.N(N), .WIDTH(WIDTH), .SELW(SELW)) bus ();

   rr_mux_stream #(.N(N), .WIDTH(WIDTH), .SELW(SELW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        ordy;
      logic [3:0]  exp_ready;
      logic        exp_ov;
      logic [1:0]  exp_sel;
      logic [15:0] exp_data;
      logic        exp_last;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Drive on the falling edge, check ready before the rising edge, check registers after it.
   task automatic step(input int idx, input vec_t v);
      @(negedge clock);
      reset         = v.rst;
      bus.in_valid  = v.valid;
      bus.out_ready = v.ordy;
`ifdef RR_MUX_STREAM_PKT_LOCK_EN
      bus.in_last   = v.last;
`endif
      #1;
      chk("in_ready", idx, 16'(bus.in_ready), 16'(v.exp_ready));
      @(posedge clock);
      #1;
      chk("out_valid", idx, 16'(bus.out_valid), 16'(v.exp_ov));
      chk("out_sel", idx, 16'(bus.out_sel), 16'(v.exp_sel));
      chk("out_data", idx, bus.out_data, v.exp_data);
`ifdef RR_MUX_STREAM_PKT_LOCK_EN
      if (v.exp_ov) chk("out_last", idx, 16'(bus.out_last), 16'(v.exp_last));
`endif
   endtask

   function automatic vec_t mk(logic rst, logic [3:0] valid, logic ordy, logic [3:0] er,
                               logic eov, logic [1:0] es, logic [15:0] ed);
      vec_t v;
      v.rst = rst; v.valid = valid; v.last = 4'b1111; v.ordy = ordy;
      v.exp_ready = er; v.exp_ov = eov; v.exp_sel = es; v.exp_data = ed; v.exp_last = 1'b1;
      return v;
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.in_valid  = '0;
      bus.out_ready = 1'b0;
`ifdef RR_MUX_STREAM_PKT_LOCK_EN
      bus.in_last   = '1;
`endif
      for (int i = 0; i < int'(N); i++) bus.in_data[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);

      // Reset with everything valid, then full-rate round robin.
      vecs[0]  = mk(1, 4'b1111, 1, 4'b0000, 0, 2'd0, 16'h0000);
      vecs[1]  = mk(1, 4'b1111, 1, 4'b0000, 0, 2'd0, 16'h0000);
      vecs[2]  = mk(0, 4'b1111, 1, 4'b0001, 1, 2'd0, 16'h1000);
      vecs[3]  = mk(0, 4'b1111, 1, 4'b0010, 1, 2'd1, 16'h1001);
      vecs[4]  = mk(0, 4'b1111, 1, 4'b0100, 1, 2'd2, 16'h1002);
      vecs[5]  = mk(0, 4'b1111, 1, 4'b1000, 1, 2'd3, 16'h1003);
      vecs[6]  = mk(0, 4'b1111, 1, 4'b0001, 1, 2'd0, 16'h1000);
      // Sparse: ch2 only (ptr 1, then ptr 3 wrapping), then ch0+ch3 with ptr 3.
      vecs[7]  = mk(0, 4'b0100, 1, 4'b0100, 1, 2'd2, 16'h1002);
      vecs[8]  = mk(0, 4'b0100, 1, 4'b0100, 1, 2'd2, 16'h1002);
      vecs[9]  = mk(0, 4'b1001, 1, 4'b1000, 1, 2'd3, 16'h1003);
      vecs[10] = mk(0, 4'b1001, 1, 4'b0001, 1, 2'd0, 16'h1000);
      // Idle drain keeps data/sel, ptr stays at 1.
      vecs[11] = mk(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 16'h1000);
      // Load into empty stage while consumer stalls, then 5 stalled cycles.
      vecs[12] = mk(0, 4'b1111, 0, 4'b0010, 1, 2'd1, 16'h1001);
      vecs[13] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 16'h1001);
      vecs[14] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 16'h1001);
      vecs[15] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 16'h1001);
      vecs[16] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 16'h1001);
      vecs[17] = mk(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 16'h1001);
      // Drain and accept ch1 together (ptr 2 wraps to ch1), out_valid stays high.
      vecs[18] = mk(0, 4'b0010, 1, 4'b0010, 1, 2'd1, 16'h1001);
      // Mid-operation reset with a pending beat and ptr=2.
      vecs[19] = mk(1, 4'b1111, 0, 4'b0000, 0, 2'd0, 16'h0000);
      vecs[20] = mk(0, 4'b1111, 1, 4'b0001, 1, 2'd0, 16'h1000);
      vecs[21] = mk(0, 4'b1111, 1, 4'b0010, 1, 2'd1, 16'h1001);

      for (int i = 0; i < 22; i++) step(i, vecs[i]);

`ifdef RR_MUX_STREAM_PKT_LOCK_EN
      begin
         vec_t v;
         step(100, mk(1, 4'b0011, 1, 4'b0000, 0, 2'd0, 16'h0000));
         // ch0 packet of 3 beats with a valid gap; ch1 continuously valid.
         v = mk(0, 4'b0011, 1, 4'b0001, 1, 2'd0, 16'h1000); v.last = 4'b0000; v.exp_last = 1'b0;
         step(101, v);
         v = mk(0, 4'b0010, 1, 4'b0000, 0, 2'd0, 16'h1000); v.last = 4'b0000;
         step(102, v);
         v = mk(0, 4'b0011, 1, 4'b0001, 1, 2'd0, 16'h1000); v.last = 4'b0000; v.exp_last = 1'b0;
         step(103, v);
         v = mk(0, 4'b0011, 1, 4'b0001, 1, 2'd0, 16'h1000); v.last = 4'b0001; v.exp_last = 1'b1;
         step(104, v);
         v = mk(0, 4'b0011, 1, 4'b0010, 1, 2'd1, 16'h1001);
         step(105, v);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rr_mux_stream.md
Name: rr_mux_stream

Overview:
- Parametrised successor to the fixed Mux/Mux4Way16/Mux8Way16 family.
- N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Selection is by internal fair round-robin arbitration, not by an external sel.
- One registered output stage. Merges multiple producers (e.g. memory-mapped I/O sources) onto one consumer bus; the winning channel index travels with the data.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 16, data width per channel.
- SELW, 2, width of channel index. Must equal ceil(log2(N)).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high.
- out_data  output  WIDTH  registered data.
- out_sel  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (reset=1 at a clock edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 combinationally while reset is high.
- Load enable: can_load = !out_valid || out_ready. Bubble-free; full throughput of one beat per cycle.
- Grant (combinational):
  - gnt = first index scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 with in_valid set.
  - No valid input means no grant.
- in_ready[i] = !reset && can_load && (grant exists) && gnt==i. in_ready is therefore one-hot or zero.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. At that clock edge:
  - out_data <= in_data[gnt]; out_sel <= gnt; out_valid <= 1.
  - ptr <= (gnt+1) mod N. Wrap from N-1 to 0.
- Output drain with no new transfer: out_valid && out_ready clears out_valid. out_data and out_sel hold their last values.
- Stall: out_valid && !out_ready means all in_ready=0, and out_data, out_sel and ptr hold stable.
- Simultaneous drain and accept in the same cycle: out_valid stays 1 and new data replaces old. No beat is lost or duplicated.
- Latency: an input beat appears on out_* exactly 1 cycle after its transfer.
- Fairness: with all N inputs continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0… Each channel waits at most N-1 beats.
- ptr advances only on a transfer. Idle cycles do not move it.
- Inputs are sampled only when in_valid && in_ready. in_data of non-granted channels is don't-care.
- Reset mid-operation: a pending output beat is discarded (out_valid=0 next cycle) and ptr returns to 0.
- N not a power of two: ptr and gnt never take values ≥N.

Optional Feature:
- Macro RR_MUX_STREAM_PKT_LOCK_EN.
- Defined:
  - Adds input port in_last (N bits) and output port out_last (1 bit, registered, reset 0, loaded with in_last[gnt] on transfer).
  - After a transfer with in_last[gnt]=0, the grant is locked to that channel: other channels get no in_ready even if that channel drops valid.
  - The lock releases on the transfer carrying in_last=1. ptr advances to gnt+1 only at that point.
  - Reset clears the lock.
- Undefined: no in_last/out_last ports; every beat re-arbitrates as described above.

Test Plan:
- Reset: hold reset 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0. First grant after release is channel 0.
- Round-robin (N=4, WIDTH=16): in_data ch i = 16'h1000+i, all valid, out_ready=1 -> out_sel sequence 0,1,2,3,0 and out_data 16'h1000,1001,1002,1003,1000 on consecutive cycles, each 1 cycle after transfer.
- Sparse valid: only ch2 valid, ptr=3 -> grant wraps to ch2, out_sel=2, next ptr=3. Then ch0 and ch3 valid -> ch3 is granted before ch0.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0000 and out_data/out_sel unchanged. out_ready=1 with ch1 valid -> drain and load in the same cycle, out_valid stays 1, out_sel=1.
- Mid-operation reset: out_valid=1, ptr=2, then assert reset one cycle -> out_valid=0, ptr=0. Next grant with all valid is channel 0.
- PKT_LOCK_EN: ch0 sends 3 beats with last on the 3rd while ch1 is continuously valid -> out_sel=0,0,0,1 and out_last=0,0,1,x. A ch0 valid gap mid-packet gives ch1 no in_ready.
